// File: rtl/arm7tdmi_pkg.sv
// Shared types and constants for the ARM7TDMI instruction prefetch path.
package arm7tdmi_pkg;

  localparam int unsigned PF_ADDR_W = 32;

  localparam logic [1:0]           IMEM_SIZE_WORD = 2'b10;
  localparam logic [PF_ADDR_W-1:0] LOW_VEC        = 32'h0000_0000;
  localparam logic [PF_ADDR_W-1:0] HIGH_VEC       = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_REQ,
    PF_HALT
  } pf_state_t;

  // One fetched word, its word address and whether the fetch faulted.
  typedef struct packed {
    logic [31:0]          word;
    logic [PF_ADDR_W-3:0] waddr;
    logic                 abort;
  } pf_entry_t;

endpackage

// File: rtl/arm7tdmi_pf_fifo.sv
// Generic circular FIFO, DEPTH a power of two; clear beats push/pop.
module arm7tdmi_pf_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify requests against occupancy.
  always_comb begin
    empty   = (count == '0);
    full    = (count == FULL_CNT);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rdata   = mem[rd_ptr];
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arm7tdmi_prefetch_queue.sv
// Instruction prefetch queue: word fetches ahead of decode, Thumb halfword
// split, per-entry abort tagging and stale-response discard after redirect.
module arm7tdmi_prefetch_queue #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] LOW_VEC  = ADDR_W'(arm7tdmi_pkg::LOW_VEC),
  parameter logic [ADDR_W-1:0] HIGH_VEC = ADDR_W'(arm7tdmi_pkg::HIGH_VEC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  input  logic                   high_vectors,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_addr,
  input  logic                   redirect_thumb,
  output logic [ADDR_W-1:0]      imem_vaddr,
  output logic                   imem_req,
  output logic [1:0]             imem_size,
  input  logic [31:0]            imem_rdata,
  input  logic                   imem_ready,
  input  logic                   imem_abort,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [31:0]            instruction,
  output logic [ADDR_W-1:0]      instr_addr,
  output logic                   instr_thumb,
  output logic                   instr_abort,
  output logic [$clog2(DEPTH):0] q_count
);

  import arm7tdmi_pkg::*;

  pf_state_t         state;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] req_addr;
  logic              discard;
  logic              thumb;
  logic              hw_sel;

  pf_entry_t         push_entry;
  pf_entry_t         head;
  logic              push;
  logic              pop;
  logic              consume;
  logic              empty;
  logic              full;
  logic [ADDR_W-3:0] head_waddr;
  logic              unused_addr_bit;

  assign unused_addr_bit = redirect_addr[0];

  arm7tdmi_pf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(pf_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .count (q_count),
    .empty (empty),
    .full  (full)
  );

  // Accept responses into the queue and decide when the head is retired.
  always_comb begin
    push             = (state == PF_REQ) && imem_ready && !redirect && !discard;
    push_entry       = '0;
    push_entry.word  = imem_rdata;
    push_entry.waddr = (PF_ADDR_W-2)'(req_addr[ADDR_W-1:2]);
    push_entry.abort = imem_abort;
    consume          = !empty && instr_ready && !redirect;
    pop              = consume && (head.abort || !thumb || hw_sel);
  end

  // Fetch FSM plus instruction-set/halfword tracking; redirect wins last.
  // req_addr is kept separate from fetch_addr so a redirect during an
  // outstanding request can retarget fetching while the bus address holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PF_IDLE;
      fetch_addr <= high_vectors ? HIGH_VEC : LOW_VEC;
      req_addr   <= '0;
      discard    <= 1'b0;
      thumb      <= 1'b0;
      hw_sel     <= 1'b0;
    end else begin
      case (state)
        PF_IDLE: begin
          if (fetch_en && !redirect && !full) begin
            state    <= PF_REQ;
            req_addr <= fetch_addr;
          end
        end
        PF_REQ: begin
          if (imem_ready) begin
            state   <= PF_IDLE;
            discard <= 1'b0;
            if (!redirect && !discard) begin
              fetch_addr <= fetch_addr + ADDR_W'(4);
              if (imem_abort) state <= PF_HALT;
            end
          end else if (redirect) begin
            discard <= 1'b1;
          end
        end
        PF_HALT: begin
          state <= PF_HALT;
        end
        default: state <= PF_IDLE;
      endcase

      if (consume && !head.abort) begin
        hw_sel <= thumb ? !hw_sel : 1'b0;
      end

      if (redirect) begin
        fetch_addr <= {redirect_addr[ADDR_W-1:2], 2'b00};
        thumb      <= redirect_thumb;
        hw_sel     <= redirect_thumb & redirect_addr[1];
        if (state == PF_HALT) state <= PF_IDLE;
      end
    end
  end

  // Present the queue head as an ARM word or a selected Thumb halfword.
  always_comb begin
    head_waddr  = (ADDR_W-2)'(head.waddr);
    instr_valid = !empty;
    instruction = '0;
    instr_addr  = '0;
    instr_abort = 1'b0;
    instr_thumb = thumb;
    imem_req    = (state == PF_REQ);
    imem_vaddr  = req_addr;
    imem_size   = IMEM_SIZE_WORD;
    if (!empty) begin
      instr_abort = head.abort;
      instr_addr  = {head_waddr, thumb & hw_sel, 1'b0};
      if (!head.abort) begin
        if (thumb) begin
          instruction = {16'h0000, hw_sel ? head.word[31:16] : head.word[15:0]};
        end else begin
          instruction = head.word;
        end
      end
    end
  end

endmodule

// File: doc/arm7tdmi_prefetch_queue.md
Name: arm7tdmi_prefetch_queue

Overview:
Parametrised instruction prefetch queue that replaces the fixed two-entry fetch stage between the MMU instruction port and decode.
- Issues word-aligned fetches ahead of decode into a DEPTH-entry circular queue.
- Splits each fetched word into two Thumb halfwords, so a word is fetched only once.
- Tags MMU aborts per entry instead of stalling.
- Discards stale in-flight responses after a redirect.

Parameters:
DEPTH, 4, queue entries; power of two, >=2
ADDR_W, 32, address width
LOW_VEC, 32'h0000_0000, reset fetch address when high_vectors=0
HIGH_VEC, 32'hFFFF_0000, reset fetch address when high_vectors=1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_en  in  1  allow new requests
high_vectors  in  1  CP15 V bit, sampled in reset
redirect  in  1  branch/exception/flush; one-cycle pulse
redirect_addr  in  ADDR_W  new instruction address
redirect_thumb  in  1  instruction set after redirect
imem_vaddr  out  ADDR_W  word-aligned fetch address
imem_req  out  1  request, held until imem_ready
imem_size  out  2  constant 2'b10
imem_rdata  in  32  fetch data
imem_ready  in  1  response/accept, single cycle
imem_abort  in  1  valid with imem_ready; fetch faulted
instr_valid  out  1  head instruction valid
instr_ready  in  1  decode consumes head
instruction  out  32  ARM word, or zero-extended Thumb halfword
instr_addr  out  ADDR_W  byte address of presented instruction
instr_thumb  out  1  presented instruction is Thumb
instr_abort  out  1  presented instruction carries prefetch abort
q_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
Reset (rst=1 at a clk edge):
- Queue empty. q_count=0. instr_valid=0, instr_abort=0, instruction=0, instr_addr=0.
- imem_req=0. Thumb=0. hw_sel=0. discard=0.
- fetch_addr = high_vectors ? HIGH_VEC : LOW_VEC.
- Reset mid-request drops the outstanding request silently.

Queue entry: {word[31:0], waddr[ADDR_W-1:2], abort}. Read/write pointers wrap modulo DEPTH.

FSM states:
- IDLE -> REQ when fetch_en && !redirect && !halted && (q_count + 0) < DEPTH.
- REQ: imem_req=1; imem_vaddr=fetch_addr and stable while waiting. On imem_ready: push entry unless discard; fetch_addr += 4; go IDLE. If imem_abort also, push with abort=1 and set halted.
- HALT: no requests issue until redirect.
- Back-to-back: the cycle after imem_ready returns to IDLE, so the request rate is at most one per two cycles.

Latency: a response accepted at edge N is presented (instr_valid) from N+1.

Head presentation:
- ARM: instruction = word; instr_addr = {waddr,2'b00}.
- Thumb: instruction = {16'h0, hw_sel ? word[31:16] : word[15:0]}; instr_addr = {waddr, hw_sel, 1'b0}.
- Abort entry: instruction = 0; instr_abort = 1.

Consume (instr_valid && instr_ready):
- ARM, or Thumb with hw_sel=1: pop; hw_sel <= 0.
- Thumb with hw_sel=0: hw_sel <= 1, no pop.
- Abort entry: pop.

Redirect (highest priority; overrides consume and push in the same cycle):
- Queue cleared; instr_valid=0 the next cycle.
- fetch_addr <= {redirect_addr[ADDR_W-1:2], 2'b00}; thumb <= redirect_thumb; hw_sel <= redirect_thumb & redirect_addr[1]; halted cleared.
- If a request is outstanding (state REQ, no imem_ready this cycle): keep imem_req asserted with the old address and set discard. The response is dropped, discard clears, then fetching resumes from the new fetch_addr.
- A response arriving in the same cycle as redirect is dropped.

Boundaries:
- Full: no request issues; push never overflows because issue needs q_count<DEPTH.
- Push and pop in the same cycle: q_count unchanged.
- fetch_addr wraps 0xFFFF_FFFC -> 0.
- Empty: instr_valid=0; instr_ready is ignored.
- fetch_en=0 blocks new requests only; an outstanding request completes.

Decomposition:
- Package arm7tdmi_pkg holds:
  - pf_state_t enum {PF_IDLE, PF_REQ, PF_HALT}
  - pf_entry_t packed struct
  - constants IMEM_SIZE_WORD=2'b10, LOW_VEC, HIGH_VEC
- One sub-module, arm7tdmi_pf_fifo: generic DEPTH circular FIFO with push, pop, clear, count.
- Thumb extraction and the FSM stay in the top level.

Test Plan:
- Reset, high_vectors=1, MMU ready after 1 wait cycle, ARM -> first imem_vaddr=FFFF0000; queue fills to 4 entries; words and instr_addr FFFF0000/4/8/C presented in order with instr_ready=1.
- Redirect to 0x0000_1002 with redirect_thumb=1; memory word 0x1000=0xBBBB_AAAA, 0x1004=0xDDDD_CCCC -> presents 0xBBBB @1002, 0xCCCC @1004, 0xDDDD @1006; 0x1000 fetched once.
- Redirect while imem_req pending to 0x2000 -> old response dropped; next request 0x2000; the first instruction presented has instr_addr 0x2000.
- imem_abort on fetch of 0x3008 -> entries 0x3000, 0x3004 normal; third presented with instr_abort=1, instruction=0; imem_req stays 0 until redirect.
- instr_ready=0 for 20 cycles -> q_count saturates at DEPTH; no imem_req while full; one pop re-enables a request next cycle.
- rst asserted during REQ -> next cycle imem_req=0, q_count=0, instr_valid=0.
